rca7_multiword_add_seq: RTL and testbench

//  Sequences one shared external 7-bit ripple-carry adder (8-bit result, carry-in fixed 0) to

---
 rtl/rca7_multiword_add_seq_if.sv | 40 ++++
 rtl/rca7_multiword_add_seq.sv | 167 ++++++++++++++++
 tb/tb_rca7_multiword_add_seq.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rca7_multiword_add_seq_if.sv
// rtl/rca7_multiword_add_seq_if.sv - bundle of request, response and adder signals for the sequencer
//
// Purpose: groups the request/response handshakes and the shared 7-bit adder
//   connection of rca7_multiword_add_seq into one interface.
// Signals (W = 7*NCHUNK):
//   i_req_valid / o_req_ready      request handshake
//   i_op_a, i_op_b [W-1:0]         unsigned addends
//   o_rsp_valid / i_rsp_ready      response handshake
//   o_rsp_sum [W:0]                A+B, bit W is the final carry-out
//   o_busy                         sequencer not idle
//   o_add_term1/2 [6:0]            operands to the external adder
//   i_add_result [7:0]             combinational result from the external adder
// Modports: slave = the sequencer, master = operand source/consumer/adder side.
interface rca7_multiword_add_seq_if #(
  parameter int NCHUNK = 4
);
  localparam int W = 7 * NCHUNK;

  logic         i_req_valid;
  logic         o_req_ready;
  logic [W-1:0] i_op_a;
  logic [W-1:0] i_op_b;
  logic         o_rsp_valid;
  logic         i_rsp_ready;
  logic [W:0]   o_rsp_sum;
  logic         o_busy;
  logic [6:0]   o_add_term1;
  logic [6:0]   o_add_term2;
  logic [7:0]   i_add_result;

  modport master (
    output i_req_valid, i_op_a, i_op_b, i_rsp_ready, i_add_result,
    input  o_req_ready, o_rsp_valid, o_rsp_sum, o_busy, o_add_term1, o_add_term2
  );

  modport slave (
    input  i_req_valid, i_op_a, i_op_b, i_rsp_ready, i_add_result,
    output o_req_ready, o_rsp_valid, o_rsp_sum, o_busy, o_add_term1, o_add_term2
  );
endinterface

// File: rtl/rca7_multiword_add_seq.sv
// rtl/rca7_multiword_add_seq.sv - multiword adder sequencing one shared 7-bit ripple-carry adder
//
// Purpose: performs a (7*NCHUNK)-bit unsigned addition one 7-bit chunk per cycle
//   on an external 7-bit adder whose carry-in is tied to 0. A chunk that must
//   absorb an incoming carry takes a second (increment) pass through the adder.
// Ports:
//   i_clk   clock, all state on the rising edge
//   i_rst   synchronous active-high reset
//   bus     rca7_multiword_add_seq_if.slave: request/response handshakes,
//           busy flag and the external adder terms/result
module rca7_multiword_add_seq #(
  parameter int NCHUNK = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  rca7_multiword_add_seq_if.slave bus
);
  localparam int W  = 7 * NCHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_K = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_CINC, S_RESP} state_t;

  state_t       r_state;
  state_t       w_next;

  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [W-1:0] r_sum;
  logic [CW-1:0] r_k;
  logic         r_c;    // carry into the current chunk, final carry-out in RESP
  logic [6:0]   r_s;    // raw chunk sum kept for the increment pass
  logic         r_ca;   // carry-out of the raw chunk sum

  logic [6:0]   w_a_chunk;
  logic [6:0]   w_b_chunk;
  logic         w_last;

  logic         w_req_ready;
  logic         w_rsp_valid;
  logic         w_busy;
  logic [6:0]   w_term1;
  logic [6:0]   w_term2;
  logic [W:0]   w_rsp_sum;

  assign w_last = (r_k == LAST_K);

  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int j = 0; j < NCHUNK; j++) begin
      if (r_k == CW'(j)) begin
        w_a_chunk = r_a[7*j +: 7];
        w_b_chunk = r_b[7*j +: 7];
      end
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.i_req_valid) w_next = S_ADD;
      S_ADD: begin
        if (r_c)         w_next = S_CINC;
        else if (w_last) w_next = S_RESP;
        else             w_next = S_ADD;
      end
      S_CINC: w_next = w_last ? S_RESP : S_ADD;
      S_RESP: if (bus.i_rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic; adder terms are forced to 0 outside the compute states
  always_comb begin
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_busy      = (r_state != S_IDLE);
    w_term1     = '0;
    w_term2     = '0;
    w_rsp_sum   = '0;
    case (r_state)
      S_IDLE: w_req_ready = 1'b1;
      S_ADD: begin
        w_term1 = w_a_chunk;
        w_term2 = w_b_chunk;
      end
      S_CINC: begin
        w_term1 = r_s;
        w_term2 = 7'd1;
      end
      S_RESP: begin
        w_rsp_valid = 1'b1;
        w_rsp_sum   = {r_c, r_sum};
      end
      default: ;
    endcase
  end

  assign bus.o_req_ready = w_req_ready;
  assign bus.o_rsp_valid = w_rsp_valid;
  assign bus.o_busy      = w_busy;
  assign bus.o_add_term1 = w_term1;
  assign bus.o_add_term2 = w_term2;
  assign bus.o_rsp_sum   = w_rsp_sum;

  // Datapath: each sum chunk is written once, either straight from ADD
  // (no incoming carry) or from the increment pass in CINC.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_sum <= '0;
      r_k   <= '0;
      r_c   <= 1'b0;
      r_s   <= '0;
      r_ca  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_req_valid) begin
            r_a   <= bus.i_op_a;
            r_b   <= bus.i_op_b;
            r_sum <= '0;
            r_k   <= '0;
            r_c   <= 1'b0;
          end
        end
        S_ADD: begin
          r_s  <= bus.i_add_result[6:0];
          r_ca <= bus.i_add_result[7];
          if (!r_c) begin
            for (int j = 0; j < NCHUNK; j++) begin
              if (r_k == CW'(j)) r_sum[7*j +: 7] <= bus.i_add_result[6:0];
            end
            r_c <= bus.i_add_result[7];
            if (!w_last) r_k <= r_k + CW'(1);
          end
        end
        S_CINC: begin
          for (int j = 0; j < NCHUNK; j++) begin
            if (r_k == CW'(j)) r_sum[7*j +: 7] <= bus.i_add_result[6:0];
          end
          // Raw sum and increment can never both carry, so OR is exact.
          r_c <= r_ca | bus.i_add_result[7];
          if (!w_last) r_k <= r_k + CW'(1);
        end
        default: ;
      endcase
    end
  end

  a_cinc_single_carry: assert property (
    @(posedge i_clk) disable iff (i_rst)
    (r_state == S_CINC) |-> !(r_ca && bus.i_add_result[7])
  );
endmodule

// File: tb/tb_rca7_multiword_add_seq.sv
// tb/tb_rca7_multiword_add_seq.sv - self-checking bench for rca7_multiword_add_seq
`timescale 1ns/1ps
module tb_rca7_multiword_add_seq;
  localparam int NCHUNK = 4;
  localparam int W      = 7 * NCHUNK;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rca7_multiword_add_seq_if #(.NCHUNK(NCHUNK)) bus ();

  rca7_multiword_add_seq #(.NCHUNK(NCHUNK)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // External 7-bit ripple-carry adder, carry-in 0
  assign bus.i_add_result = {1'b0, bus.o_add_term1} + {1'b0, bus.o_add_term2};

  int n_vec  = 0;
  int n_cmp  = 0;
  int n_fail = 0;
  int n_rsp  = 0;
  int rsp_mode = 0;   // 0: always ready, 1: random, 2: never ready

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_to(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // Monitor and reference model
  int            mon_ph = 0;     // 0 idle, 1 computing, 2 responding
  int            cyc = 0;
  int            t_acc = 0;
  int            mon_lat = 0;
  int            mon_ncomp = 0;
  bit            mon_first = 0;
  logic [W:0]    mon_last_sum = '0;
  logic [13:0]   mon_terms [0:15];
  logic [W:0]    m_sum;
  logic [13:0]   m_terms [$];

  task automatic build_model(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned la, lb, mask, cin;
    logic [6:0] ak, bk;
    la = 64'(a);
    lb = 64'(b);
    m_sum = (W+1)'(la + lb);
    m_terms.delete();
    for (int k = 0; k < NCHUNK; k++) begin
      mask = (64'd1 << (7*k)) - 64'd1;
      cin  = ((la & mask) + (lb & mask)) >> (7*k);
      ak = 7'(la >> (7*k));
      bk = 7'(lb >> (7*k));
      m_terms.push_back({ak, bk});
      if (cin != 0) m_terms.push_back({7'(ak + bk), 7'd1});
    end
  endtask

  always @(negedge clk) begin
    logic [13:0] et;
    cyc++;
    if (rst) begin
      mon_ph = 0;
      m_terms.delete();
    end else begin
      case (mon_ph)
        0: begin
          chk("idle_req_ready", bus.o_req_ready, 1);
          chk("idle_busy", bus.o_busy, 0);
          chk("idle_rsp_valid", bus.o_rsp_valid, 0);
          chk("idle_rsp_sum", bus.o_rsp_sum, 0);
          chk("idle_terms", {bus.o_add_term1, bus.o_add_term2}, 0);
          if (bus.i_req_valid) begin
            build_model(bus.i_op_a, bus.i_op_b);
            n_vec++;
            t_acc = cyc;
            mon_ncomp = 0;
            mon_ph = 1;
          end
        end
        1: begin
          chk("comp_req_ready", bus.o_req_ready, 0);
          chk("comp_busy", bus.o_busy, 1);
          chk("comp_rsp_valid", bus.o_rsp_valid, 0);
          et = m_terms.pop_front();
          chk("comp_terms", {bus.o_add_term1, bus.o_add_term2}, et);
          if (mon_ncomp < 16) mon_terms[mon_ncomp] = {bus.o_add_term1, bus.o_add_term2};
          mon_ncomp++;
          if (m_terms.size() == 0) begin
            mon_ph = 2;
            mon_first = 1;
          end
        end
        default: begin
          chk("rsp_valid", bus.o_rsp_valid, 1);
          chk("rsp_sum", bus.o_rsp_sum, m_sum);
          chk("rsp_req_ready", bus.o_req_ready, 0);
          chk("rsp_busy", bus.o_busy, 1);
          chk("rsp_terms", {bus.o_add_term1, bus.o_add_term2}, 0);
          if (mon_first) begin
            mon_lat = cyc - t_acc;
            mon_first = 0;
          end
          if (bus.i_rsp_ready) begin
            mon_last_sum = bus.o_rsp_sum;
            n_rsp++;
            mon_ph = 0;
          end
        end
      endcase
    end
  end

  // Response-ready driver
  initial begin
    bus.i_rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rsp_mode)
        0:       bus.i_rsp_ready = 1'b1;
        1:       bus.i_rsp_ready = 1'($urandom_range(0, 1));
        default: bus.i_rsp_ready = 1'b0;
      endcase
    end
  end

  // Called and returns at posedge+2
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int t;
    bit acc;
    t = 0;
    acc = 0;
    bus.i_req_valid = 1'b1;
    bus.i_op_a = a;
    bus.i_op_b = b;
    while (!acc && t < 500) begin
      @(negedge clk);
      if (bus.o_req_ready) acc = 1;
      else t++;
    end
    if (!acc) fail_to("send_accept");
    @(posedge clk);
    #2;
    bus.i_req_valid = 1'b0;
    bus.i_op_a = W'($urandom);
    bus.i_op_b = W'($urandom);
  endtask

  task automatic wait_rsp(input int target);
    int t;
    t = 0;
    while (n_rsp < target && t < 2000) begin
      @(posedge clk);
      #2;
      t++;
    end
    if (n_rsp < target) fail_to("wait_rsp");
  endtask

  task automatic wait_resp_phase();
    int t;
    t = 0;
    while (mon_ph != 2 && t < 100) begin
      @(posedge clk);
      #2;
      t++;
    end
    if (mon_ph != 2) fail_to("wait_resp_phase");
  endtask

  function automatic logic [W-1:0] gen();
    logic [W-1:0] v;
    logic [6:0]   ch;
    v = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      case ($urandom_range(0, 3))
        0:       ch = 7'h7F;
        1:       ch = 7'h00;
        default: ch = 7'($urandom);
      endcase
      v[7*k +: 7] = ch;
    end
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    bus.i_req_valid = 1'b0;
    bus.i_op_a = '0;
    bus.i_op_b = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #2;

    // Small add, no carries
    base = n_rsp;
    send(28'h0000005, 28'h0000003);
    wait_rsp(base + 1);
    chk("t1_sum", mon_last_sum, 29'h0000008);
    chk("t1_latency", mon_lat, 5);

    // Carry into chunk 1
    base = n_rsp;
    send(28'h000007F, 28'h0000001);
    wait_rsp(base + 1);
    chk("t2_sum", mon_last_sum, 29'h0000080);
    chk("t2_latency", mon_lat, 6);
    chk("t2_chunk1_add_terms", mon_terms[1], 14'h0000);
    chk("t2_chunk1_cinc_terms", mon_terms[2], 14'h0001);

    // Carry ripples through every chunk
    base = n_rsp;
    send(28'hFFFFFFF, 28'h0000001);
    wait_rsp(base + 1);
    chk("t3_sum", mon_last_sum, 29'h10000000);
    chk("t3_carry_bit", mon_last_sum[28], 1);
    chk("t3_latency", mon_lat, 8);

    // Max operands with a stalled consumer and a pending request
    rsp_mode = 2;
    base = n_rsp;
    send(28'hFFFFFFF, 28'hFFFFFFF);
    wait_resp_phase();
    bus.i_req_valid = 1'b1;
    bus.i_op_a = 28'h1234567;
    bus.i_op_b = 28'h0ABCDEF;
    repeat (10) begin
      @(posedge clk);
      #2;
    end
    @(negedge clk);
    chk("t4_sum_held", bus.o_rsp_sum, 29'h1FFFFFFE);
    chk("t4_valid_held", bus.o_rsp_valid, 1);
    chk("t4_req_ready_low", bus.o_req_ready, 0);
    chk("t4_no_handshake", n_rsp, base);
    chk("t4_latency", mon_lat, 8);
    @(posedge clk);
    #2;
    rsp_mode = 0;
    send(28'h1234567, 28'h0ABCDEF);
    wait_rsp(base + 2);
    chk("t4_next_sum", mon_last_sum, 29'h1CF1356);

    // Reset during chunk 2
    send(28'h0204081, 28'h0204081);
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    base = n_rsp;
    @(negedge clk);
    chk("t5_after_reset_busy", bus.o_busy, 0);
    chk("t5_after_reset_ready", bus.o_req_ready, 1);
    repeat (6) begin
      @(posedge clk);
      #2;
    end
    chk("t5_no_response", n_rsp, base);
    send(28'h0003FFF, 28'h0000001);
    wait_rsp(base + 1);
    chk("t5_next_sum", mon_last_sum, 29'h0004000);
    chk("t5_next_latency", mon_lat, 7);

    // Random back-to-back requests with random back-pressure
    rsp_mode = 1;
    base = n_rsp;
    for (int i = 0; i < 150; i++) begin
      send(gen(), gen());
    end
    rsp_mode = 0;
    wait_rsp(base + 150);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
